// File: rtl/tick_prescaler.sv
// Programmable tick prescaler: emits a one-cycle enable pulse every D+1 cycles
// while running, with optional single-tick mode and a guarded divisor load.
module tick_prescaler #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned ONESHOT_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             oneshot,
    input  logic             load,
    input  logic [WIDTH-1:0] div_val,
    output logic             tick,
    output logic             busy,
    output logic [WIDTH-1:0] phase,
    output logic             load_err
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   phase_q, phase_d;
    logic [WIDTH-1:0]   div_q, div_d;
    logic               tick_q, tick_d;
    logic               oneshot_q, oneshot_d;
    logic               load_err_q, load_err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            phase_q    <= '0;
            div_q      <= '0;
            tick_q     <= 1'b0;
            oneshot_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            div_q      <= div_d;
            tick_q     <= tick_d;
            oneshot_q  <= oneshot_d;
            load_err_q <= load_err_d;
        end
    end

    // tick is registered from the compare on the next phase, so it is high in
    // the very cycle phase shows D; a load coinciding with start is used at once.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        div_d      = div_q;
        tick_d     = 1'b0;
        oneshot_d  = oneshot_q;
        load_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                phase_d = '0;
                if (load) begin
                    div_d = div_val;
                end
                if (start) begin
                    state_d   = ST_RUN;
                    tick_d    = (div_d == '0);
                    oneshot_d = oneshot && (ONESHOT_EN != 0);
                end
            end
            ST_RUN: begin
                load_err_d = load;
                if (stop || (oneshot_q && tick_q)) begin
                    state_d = ST_IDLE;
                    phase_d = '0;
                end else begin
                    phase_d = (phase_q == div_q) ? '0 : phase_q + WIDTH'(1);
                    tick_d  = (phase_d == div_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase
    end

    assign tick     = tick_q;
    assign busy     = (state_q == ST_RUN);
    assign phase    = phase_q;
    assign load_err = load_err_q;

endmodule
